// File: rtl/jtframe_sdram_arb_if.sv
// Game-interface bus between the slot arbiter and the SDRAM controller.
// master = arbiter side, slave = controller side.
interface jtframe_sdram_arb_if;
    logic        read_req;
    logic [21:0] sdram_addr;
    logic [1:0]  sdram_bank;
    logic        sdram_rnw;
    logic [15:0] data_write;
    logic [1:0]  sdram_wrmask;
    logic        refresh_en;
    logic        sdram_ack;
    logic        data_rdy;
    logic [31:0] data_read;

    modport master (
        output read_req, sdram_addr, sdram_bank, sdram_rnw,
               data_write, sdram_wrmask, refresh_en,
        input  sdram_ack, data_rdy, data_read
    );

    modport slave (
        input  read_req, sdram_addr, sdram_bank, sdram_rnw,
               data_write, sdram_wrmask, refresh_en,
        output sdram_ack, data_rdy, data_read
    );
endinterface

// File: rtl/jtframe_sdram_arb.sv
// Four-slot round-robin arbiter in front of the SDRAM controller.
// Slot 0 is read/write work RAM, slots 1-3 are read-only ROM.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no transaction in flight; grant or allow refresh
// WAIT_ACK  | read_req high, request latched, waiting for sdram_ack
// WAIT_DATA | controller accepted; waiting for data_rdy to close the slot
module jtframe_sdram_arb #(
    parameter logic [1:0] BANK0 = 2'd0,
    parameter logic [1:0] BANK1 = 2'd1,
    parameter logic [1:0] BANK2 = 2'd2,
    parameter logic [1:0] BANK3 = 2'd3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       downloading,
    input  logic [3:0]                 slot_req,
    input  logic [87:0]                slot_addr,
    input  logic                       slot0_rnw,
    input  logic [15:0]                slot0_din,
    input  logic [1:0]                 slot0_wrmask,
    output logic [3:0]                 slot_ok,
    output logic [31:0]                slot_dout,
    jtframe_sdram_arb_if.master        sdram
);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

    state_t      state_q, state_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  cur_q, cur_d;
    logic        read_req_q, read_req_d;
    logic [21:0] addr_q, addr_d;
    logic [1:0]  bank_q, bank_d;
    logic        rnw_q, rnw_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  wrmask_q, wrmask_d;
    logic        refresh_q, refresh_d;
    logic [3:0]  ok_q, ok_d;
    logic [31:0] dout_q, dout_d;

    logic [3:0][21:0] addr_v;
    logic             grant_vld;
    logic [1:0]       grant_idx;
    logic [1:0]       cand;

    assign addr_v = slot_addr;

    function automatic logic [1:0] bank_of(input logic [1:0] s);
        case (s)
            2'd0:    bank_of = BANK0;
            2'd1:    bank_of = BANK1;
            2'd2:    bank_of = BANK2;
            default: bank_of = BANK3;
        endcase
    endfunction

    // Round-robin search starting just after the last winner.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_q;
        cand      = last_q;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!grant_vld && slot_req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cur_d      = cur_q;
        read_req_d = read_req_q;
        addr_d     = addr_q;
        bank_d     = bank_q;
        rnw_d      = rnw_q;
        wdata_d    = wdata_q;
        wrmask_d   = wrmask_q;
        refresh_d  = 1'b0;
        ok_d       = 4'b0000;
        dout_d     = dout_q;
        case (state_q)
            IDLE: begin
                refresh_d = ~|slot_req & ~downloading;
                if (!downloading && grant_vld) begin
                    addr_d = addr_v[grant_idx];
                    bank_d = bank_of(grant_idx);
                    if (grant_idx == 2'd0) begin
                        rnw_d    = slot0_rnw;
                        wdata_d  = slot0_din;
                        wrmask_d = slot0_wrmask;
                    end else begin
                        rnw_d    = 1'b1;
                        wrmask_d = 2'b00;
                    end
                    read_req_d = 1'b1;
                    cur_d      = grant_idx;
                    last_d     = grant_idx;
                    state_d    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // A data_rdy coinciding with ack is ignored; data follows later.
                if (sdram.sdram_ack) begin
                    read_req_d = 1'b0;
                    state_d    = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (sdram.data_rdy) begin
                    dout_d  = sdram.data_read;
                    ok_d    = 4'(4'b0001 << cur_q);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 2'd3;
            cur_q      <= 2'd0;
            read_req_q <= 1'b0;
            addr_q     <= 22'd0;
            bank_q     <= 2'd0;
            rnw_q      <= 1'b1;
            wdata_q    <= 16'd0;
            wrmask_q   <= 2'b00;
            refresh_q  <= 1'b0;
            ok_q       <= 4'b0000;
            dout_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cur_q      <= cur_d;
            read_req_q <= read_req_d;
            addr_q     <= addr_d;
            bank_q     <= bank_d;
            rnw_q      <= rnw_d;
            wdata_q    <= wdata_d;
            wrmask_q   <= wrmask_d;
            refresh_q  <= refresh_d;
            ok_q       <= ok_d;
            dout_q     <= dout_d;
        end
    end

    assign sdram.read_req     = read_req_q;
    assign sdram.sdram_addr   = addr_q;
    assign sdram.sdram_bank   = bank_q;
    assign sdram.sdram_rnw    = rnw_q;
    assign sdram.data_write   = wdata_q;
    assign sdram.sdram_wrmask = wrmask_q;
    assign sdram.refresh_en   = refresh_q;
    assign slot_ok            = ok_q;
    assign slot_dout          = dout_q;
endmodule
